// File: rtl/pipe_stage_reg.sv
// Configurable pipeline-boundary register: valid/ready handshake, optional
// two-entry skid buffer, flush-to-bubble, global halt and saturating bubble counter.
module pipe_stage_reg #(
   parameter int CTRL_W = 2,
   parameter int RD_W   = 5,
   parameter int DATA_W = 64,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              halt_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [RD_W-1:0]   in_rd_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [RD_W-1:0]   out_rd_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_FULL     = 2'd1,
      ST_SKIDFULL = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [CTRL_W-1:0]   skid_ctrl_r;
   logic [RD_W-1:0]     skid_rd_r;
   logic [DATA_W-1:0]   skid_data_r;
   logic [CTRL_W-1:0]   ctrl_nxt_s;
   logic [RD_W-1:0]     rd_nxt_s;
   logic [DATA_W-1:0]   data_nxt_s;
   logic [CTRL_W-1:0]   skid_ctrl_nxt_s;
   logic [RD_W-1:0]     skid_rd_nxt_s;
   logic [DATA_W-1:0]   skid_data_nxt_s;
   logic [CNT_W-1:0]    bub_nxt_s;
   logic                in_fire_s;
   logic                out_fire_s;
   logic                ld_in_s;
   logic                ld_skid_in_s;
   logic                ld_from_skid_s;
   logic                clr_main_s;

   // With the skid buffer, ready depends on registered state only.
   if (SKID != 0) begin : g_skid
      assign in_ready_o = (state_r != ST_SKIDFULL) & ~halt_i & ~rst_i;
   end else begin : g_noskid
      assign in_ready_o = ((state_r == ST_EMPTY) | out_ready_i) & ~halt_i & ~rst_i;
   end

   assign in_fire_s  = in_valid_i & in_ready_o;
   assign out_fire_s = out_valid_o & out_ready_i & ~halt_i;

   // Next-state and datapath load decode; flush outranks halt.
   always_comb begin
      state_nxt_s    = state_r;
      ld_in_s        = 1'b0;
      ld_skid_in_s   = 1'b0;
      ld_from_skid_s = 1'b0;
      clr_main_s     = 1'b0;
      if (flush_i) begin
         state_nxt_s = ST_EMPTY;
         clr_main_s  = 1'b1;
      end else if (halt_i) begin
         state_nxt_s = state_r;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s = ST_FULL;
                  ld_in_s     = 1'b1;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (in_fire_s & (out_fire_s | (SKID == 0))) begin
                  state_nxt_s = ST_FULL;
                  ld_in_s     = 1'b1;
               end else if (in_fire_s) begin
                  state_nxt_s  = ST_SKIDFULL;
                  ld_skid_in_s = 1'b1;
               end else if (out_fire_s) begin
                  state_nxt_s = ST_EMPTY;
                  clr_main_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            ST_SKIDFULL: begin
               if (out_fire_s) begin
                  state_nxt_s    = ST_FULL;
                  ld_from_skid_s = 1'b1;
               end else begin
                  state_nxt_s = ST_SKIDFULL;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
               clr_main_s  = 1'b1;
            end
         endcase
      end
   end

   // Next values of the registered outputs, skid entry and bubble counter.
   always_comb begin
      ctrl_nxt_s      = out_ctrl_o;
      rd_nxt_s        = out_rd_o;
      data_nxt_s      = out_data_o;
      skid_ctrl_nxt_s = skid_ctrl_r;
      skid_rd_nxt_s   = skid_rd_r;
      skid_data_nxt_s = skid_data_r;
      bub_nxt_s       = bubble_cnt_o;
      if (clr_main_s) begin
         ctrl_nxt_s = {CTRL_W{1'b0}};
         rd_nxt_s   = {RD_W{1'b0}};
      end else if (ld_in_s) begin
         ctrl_nxt_s = in_ctrl_i;
         rd_nxt_s   = in_rd_i;
         data_nxt_s = in_data_i;
      end else if (ld_from_skid_s) begin
         ctrl_nxt_s = skid_ctrl_r;
         rd_nxt_s   = skid_rd_r;
         data_nxt_s = skid_data_r;
      end else begin
         data_nxt_s = out_data_o;
      end
      if (ld_skid_in_s) begin
         skid_ctrl_nxt_s = in_ctrl_i;
         skid_rd_nxt_s   = in_rd_i;
         skid_data_nxt_s = in_data_i;
      end else begin
         skid_data_nxt_s = skid_data_r;
      end
      if (~halt_i & ~out_valid_o & (bubble_cnt_o != {CNT_W{1'b1}})) begin
         bub_nxt_s = bubble_cnt_o + CNT_W'(1);
      end else begin
         bub_nxt_s = bubble_cnt_o;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_EMPTY;
         out_valid_o  <= 1'b0;
         out_ctrl_o   <= {CTRL_W{1'b0}};
         out_rd_o     <= {RD_W{1'b0}};
         out_data_o   <= {DATA_W{1'b0}};
         skid_ctrl_r  <= {CTRL_W{1'b0}};
         skid_rd_r    <= {RD_W{1'b0}};
         skid_data_r  <= {DATA_W{1'b0}};
         bubble_cnt_o <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         out_valid_o  <= (state_nxt_s != ST_EMPTY);
         out_ctrl_o   <= ctrl_nxt_s;
         out_rd_o     <= rd_nxt_s;
         out_data_o   <= data_nxt_s;
         skid_ctrl_r  <= skid_ctrl_nxt_s;
         skid_rd_r    <= skid_rd_nxt_s;
         skid_data_r  <= skid_data_nxt_s;
         bubble_cnt_o <= bub_nxt_s;
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-boundary register for the five-stage core. It replaces the fixed-width stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single configurable block. The block adds a valid/ready handshake, an optional two-entry skid buffer, a flush path that injects a bubble, a global halt freeze and a saturating bubble counter. One instance sits between each pair of adjacent stages.

## Interface
Parameters:
- CTRL_W, 2, width of control bundle (WB/MEM/EX bits); forced to 0 on bubbles
- RD_W, 5, destination-register index width; forced to 0 on bubbles
- DATA_W, 64, payload width (e.g. {addr, data})
- SKID, 1, 0 = single register with combinational ready pass-through; 1 = two-entry skid buffer with registered ready
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- halt_i  in  1  global freeze; no state change, no transfers
- flush_i  in  1  discard all held entries
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  block can accept a beat
- in_ctrl_i  in  CTRL_W  upstream control
- in_rd_i  in  RD_W  upstream destination register
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  downstream beat valid
- out_ready_i  in  1  downstream accepts
- out_ctrl_o  out  CTRL_W  control; 0 when out_valid_o=0
- out_rd_o  out  RD_W  destination register; 0 when out_valid_o=0
- out_data_o  out  DATA_W  payload; held, not cleared, on bubbles
- bubble_cnt_o  out  CNT_W  count of non-halted cycles with out_valid_o=0

## Operation
- Transfer definitions:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i & ~halt_i.
- Priority per cycle: rst_i > flush_i > halt_i > normal.
- Reset: state EMPTY, out_valid_o=0, out_ctrl_o=0, out_rd_o=0, out_data_o=0, bubble_cnt_o=0. in_ready_o=0 while rst_i=1.
- Flush: next state EMPTY and both entries invalid. Main ctrl/rd cleared to 0, data held. An in_fire in the flush cycle is dropped. in_ready_o is unaffected in the flush cycle.
- Halt: all registers and the counter hold. in_ready_o=0. out_valid_o and out_* hold their values. out_ready_i is ignored.
- SKID=1 states:
  - EMPTY: in_fire -> FULL.
  - FULL: in_fire & out_fire -> FULL (main replaced). in_fire & ~out_fire -> SKIDFULL (beat written to skid). ~in_fire & out_fire -> EMPTY.
  - SKIDFULL: out_fire -> FULL (skid moves to main). No in_fire possible.
  - in_ready_o = (state != SKIDFULL) & ~halt_i & ~rst_i, from registered state only. There is no combinational path from out_ready_i.
- SKID=0: states EMPTY/FULL only. in_ready_o = (~FULL | out_ready_i) & ~halt_i & ~rst_i. Transitions match SKID=1 without SKIDFULL.
- Ordering: beats exit in strict arrival order. No beat is duplicated or lost except by flush.
- Bubble counter: increments by 1 on each cycle with ~rst_i & ~halt_i & ~out_valid_o. Saturates at all-ones. Cleared only by reset; flush does not clear it.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is on out_* after edge N.
- Throughput: 1 beat/cycle while out_ready_i=1 and halt_i=0.
- SKID=1 backpressure: out_ready_i falls in cycle N, and a beat offered in cycle N is still accepted into skid. in_ready_o falls after edge N.
- Recovery: out_ready_i rises with state SKIDFULL; main drains at that edge, and in_ready_o rises the next cycle.
- Simultaneous flush & halt: flush wins; entries cleared.
- Simultaneous in_fire & out_fire in FULL: no bubble; out_* shows the new beat next cycle.
- All outputs are registers, except in_ready_o, which is combinational in SKID=0 only.

## Test plan
- Reset: hold rst_i=1 two cycles with in_valid_i=1 -> in_ready_o=0, all outputs 0, bubble_cnt_o=0. After release, the first cycle with out_valid_o=0 makes bubble_cnt_o=1.
- Streaming, SKID=1, out_ready_i=1: send beats data=1..8, ctrl=2'b11, rd=5 -> out_data_o shows 1..8 on consecutive cycles starting 1 cycle late, no gaps.
- Backpressure, SKID=1: stream 1..6 and drop out_ready_i for 3 cycles mid-stream -> exactly one extra beat is absorbed, and in_ready_o is 0 one cycle after the drop. Output is 1..6 in order with none lost.
- Flush: with SKIDFULL holding beats 4,5, assert flush_i with in_valid_i=1 (beat 6) -> next cycle out_valid_o=0, out_ctrl_o=0, out_rd_o=0. Beats 4,5,6 never appear.
- Halt: assert halt_i 4 cycles with out_ready_i=1 while FULL with beat 7 -> out_* hold beat 7, in_ready_o=0, bubble_cnt_o unchanged. Beat 7 fires on the first post-halt cycle.
- Saturation, CNT_W=4: idle 20 cycles -> bubble_cnt_o stops at 15. SKID=0 variant with out_ready_i=0 while FULL -> in_ready_o=0 in the same cycle.
